// File: rtl/nes_joypad_port.sv
// NES controller port fed from USB-side button state, with turbo A/B and conflicting-direction masking.
// The console strobe and read clock are resynchronized into usbclk; joy_data comes straight from the shift register.
module nes_joypad_port #(
    parameter int TURBO_HALF = 200000
) (
    input  logic       usbclk,
    input  logic       usbrst_n,
    input  logic [7:0] btn_nes,
    input  logic       btn_x,
    input  logic       btn_y,
    input  logic       conerr,
    input  logic       joy_strobe,
    input  logic       joy_rd,
    output logic       joy_data,
    output logic [7:0] btn_state,
    output logic [3:0] rd_count
);
    localparam int TW = (TURBO_HALF > 1) ? $clog2(TURBO_HALF) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TURBO_HALF - 1);

    // [0]=first sync stage, [1]=synchronized level, [2]=history for edge detect
    logic [2:0]    strb_sync_q;
    logic [2:0]    rd_sync_q;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          turbo_ph_q, turbo_ph_d;
    logic [7:0]    state_q, state_d;
    logic [7:0]    sr_q, sr_d;
    logic [3:0]    cnt_q, cnt_d;

    logic strobe_lvl;
    logic rd_rise;

    assign strobe_lvl = strb_sync_q[1];
    assign rd_rise    = rd_sync_q[1] & ~rd_sync_q[2];

    // Idle turbo parks in the "pressed" phase so a fresh press shows up immediately.
    always_comb begin
        tcnt_d     = tcnt_q;
        turbo_ph_d = turbo_ph_q;
        if (conerr || !(btn_x || btn_y)) begin
            tcnt_d     = '0;
            turbo_ph_d = 1'b1;
        end else if (tcnt_q == TCNT_LAST) begin
            tcnt_d     = '0;
            turbo_ph_d = ~turbo_ph_q;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = btn_nes;
        state_d[0] = btn_nes[0] | (btn_x & turbo_ph_q);
        state_d[1] = btn_nes[1] | (btn_y & turbo_ph_q);
        if (state_d[7] && state_d[6]) begin
            state_d[7:6] = 2'b00;
        end
        if (state_d[5] && state_d[4]) begin
            state_d[5:4] = 2'b00;
        end
        if (conerr) begin
            state_d = '0;
        end
    end

    // A held strobe reloads every cycle and masks read clocks entirely.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (strobe_lvl) begin
            sr_d  = state_q;
            cnt_d = 4'd0;
        end else if (rd_rise) begin
            sr_d = {1'b1, sr_q[7:1]};
            if (cnt_q < 4'd8) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            strb_sync_q <= '0;
            rd_sync_q   <= '0;
            tcnt_q      <= '0;
            turbo_ph_q  <= 1'b1;
            state_q     <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
        end else begin
            strb_sync_q <= {strb_sync_q[1:0], joy_strobe};
            rd_sync_q   <= {rd_sync_q[1:0], joy_rd};
            tcnt_q      <= tcnt_d;
            turbo_ph_q  <= turbo_ph_d;
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign joy_data  = sr_q[0];
    assign btn_state = state_q;
    assign rd_count  = cnt_q;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Bench for nes_joypad_port: directed literal checks plus randomized traffic against a cycle-level reference model.
module tb_nes_joypad_port;
    localparam int TH = 4;

    logic       usbclk     = 1'b0;
    logic       usbrst_n   = 1'b0;
    logic [7:0] btn_nes    = '0;
    logic       btn_x      = 1'b0;
    logic       btn_y      = 1'b0;
    logic       conerr     = 1'b0;
    logic       joy_strobe = 1'b0;
    logic       joy_rd     = 1'b0;
    logic       joy_data;
    logic [7:0] btn_state;
    logic [3:0] rd_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 usbclk = ~usbclk;

    nes_joypad_port #(.TURBO_HALF(TH)) dut (
        .usbclk    (usbclk),
        .usbrst_n  (usbrst_n),
        .btn_nes   (btn_nes),
        .btn_x     (btn_x),
        .btn_y     (btn_y),
        .conerr    (conerr),
        .joy_strobe(joy_strobe),
        .joy_rd    (joy_rd),
        .joy_data  (joy_data),
        .btn_state (btn_state),
        .rd_count  (rd_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw input history, latched byte plus read index, turbo run length.
    bit         strb_hist[$];
    bit         rd_hist[$];
    logic [7:0] m_state = '0;
    logic [7:0] m_lat   = '0;
    int         m_shifts = 0;
    int         m_run    = 0;

    task automatic model_reset();
        strb_hist.delete();
        rd_hist.delete();
        repeat (4) begin
            strb_hist.push_back(1'b0);
            rd_hist.push_back(1'b0);
        end
        m_state  = '0;
        m_lat    = '0;
        m_shifts = 0;
        m_run    = 0;
    endtask

    task automatic model_step();
        logic [7:0] eff;
        bit         ph;
        bit         act;
        strb_hist.push_back(joy_strobe);
        void'(strb_hist.pop_front());
        rd_hist.push_back(joy_rd);
        void'(rd_hist.pop_front());
        // the console's view lags the raw pins by two samples
        if (strb_hist[1]) begin
            m_lat    = m_state;
            m_shifts = 0;
        end else if (rd_hist[1] && !rd_hist[0]) begin
            if (m_shifts < 9) m_shifts++;
        end
        act = (btn_x || btn_y) && !conerr;
        ph  = ((m_run / TH) % 2) == 0;
        eff = btn_nes;
        if (btn_x && ph) eff[0] = 1'b1;
        if (btn_y && ph) eff[1] = 1'b1;
        if (eff[7] && eff[6]) eff[7:6] = 2'b00;
        if (eff[5] && eff[4]) eff[5:4] = 2'b00;
        if (conerr) eff = '0;
        m_state = eff;
        m_run   = act ? m_run + 1 : 0;
    endtask

    function automatic logic m_data();
        logic [2:0] idx;
        if (m_shifts >= 8) return 1'b1;
        idx = 3'(m_shifts);
        return m_lat[idx];
    endfunction

    function automatic logic [3:0] m_count();
        return (m_shifts > 8) ? 4'd8 : 4'(m_shifts);
    endfunction

    always @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) model_reset();
        else           model_step();
    end

    always @(negedge usbclk) begin
        if (cmp_en) begin
            chk("cyc_joy_data",  32'(joy_data),  32'(m_data()));
            chk("cyc_btn_state", 32'(btn_state), 32'(m_state));
            chk("cyc_rd_count",  32'(rd_count),  32'(m_count()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge usbclk);
        #2;
    endtask

    task automatic strobe_pulse();
        joy_strobe = 1'b1;
        tick(4);
        joy_strobe = 1'b0;
        tick(4);
    endtask

    task automatic rd_pulse();
        joy_rd = 1'b1;
        tick(4);
        joy_rd = 1'b0;
        tick(4);
    endtask

    initial begin
        logic [9:0]  seq;
        logic [15:0] tpat;
        seq  = 10'b1100001001;
        tpat = 16'h0F0F;

        usbrst_n = 1'b0;
        tick(3);
        cmp_en = 1'b1;
        chk("rst_joy_data",  32'(joy_data),  32'd0);
        chk("rst_btn_state", 32'(btn_state), 32'd0);
        chk("rst_rd_count",  32'(rd_count),  32'd0);
        usbrst_n = 1'b1;
        tick(2);

        // Opposing directions cancel pairwise
        btn_nes = 8'hF0;
        tick(1);
        chk("mask_F0", 32'(btn_state), 32'h00);
        btn_nes = 8'h50;
        tick(1);
        chk("mask_50", 32'(btn_state), 32'h50);

        // Serial order A,B,Select,Start,...,Right then trailing 1s
        btn_nes = 8'h09;
        tick(2);
        strobe_pulse();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("serial_bit%0d", i), 32'(joy_data), 32'(seq[i]));
            rd_pulse();
        end
        chk("serial_rd_count_sat", 32'(rd_count), 32'd8);

        // Turbo A: 4 cycles on, 4 off, starting on the first edge after press
        btn_nes = 8'h00;
        tick(2);
        btn_x = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge usbclk);
            #1;
            chk($sformatf("turbo_c%0d", i), 32'(btn_state[0]), 32'(tpat[i]));
        end
        btn_x = 1'b0;
        tick(2);

        // Connection error blanks everything
        btn_nes = 8'hFF;
        conerr  = 1'b1;
        tick(2);
        chk("conerr_state", 32'(btn_state), 32'd0);
        strobe_pulse();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("conerr_bit%0d", i), 32'(joy_data), 32'd0);
            rd_pulse();
        end
        conerr = 1'b0;

        // Latched byte is frozen once the synchronized strobe has dropped
        btn_nes = 8'h01;
        tick(2);
        joy_strobe = 1'b1;
        tick(4);
        joy_strobe = 1'b0;
        tick(4);
        btn_nes = 8'h02;
        tick(2);
        chk("frozen_A", 32'(joy_data), 32'd1);
        rd_pulse();
        chk("frozen_B", 32'(joy_data), 32'd0);
        chk("frozen_cnt", 32'(rd_count), 32'd1);
        joy_strobe = 1'b1;
        tick(4);
        chk("strobe_cnt_clr", 32'(rd_count), 32'd0);
        rd_pulse();
        chk("rd_during_strobe", 32'(rd_count), 32'd0);
        joy_strobe = 1'b0;
        tick(4);
        chk("after_strobe_A", 32'(joy_data), 32'd0);

        // Async reset mid-read
        btn_nes = 8'h08;
        tick(2);
        strobe_pulse();
        repeat (3) rd_pulse();
        chk("pre_rst_cnt",  32'(rd_count), 32'd3);
        chk("pre_rst_data", 32'(joy_data), 32'd1);
        usbrst_n = 1'b0;
        #1;
        chk("async_rst_data", 32'(joy_data), 32'd0);
        chk("async_rst_cnt",  32'(rd_count), 32'd0);
        tick(2);
        usbrst_n = 1'b1;
        tick(2);
        chk("post_rst_data0", 32'(joy_data), 32'd0);
        rd_pulse();
        chk("post_rst_data1", 32'(joy_data), 32'd0);
        chk("post_rst_cnt",   32'(rd_count), 32'd1);

        // Randomized traffic, checked every cycle against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) btn_nes = 8'($urandom);
            if ($urandom_range(0, 11) == 0) joy_strobe = ~joy_strobe;
            if ($urandom_range(0, 2) == 0)  joy_rd = ~joy_rd;
            if ($urandom_range(0, 29) == 0) btn_x = ~btn_x;
            if ($urandom_range(0, 29) == 0) btn_y = ~btn_y;
            if ($urandom_range(0, 63) == 0) conerr = ~conerr;
            tick(1);
        end

        cmp_en = 1'b0;
        tick(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_joypad_port.md
NES_JOYPAD_PORT -- requirements
Module: nes_joypad_port

Interface
REQ-001 SHALL have parameter TURBO_HALF, default 200000, meaning usbclk cycles per turbo phase (30 Hz turbo at 12 MHz).
REQ-002 SHALL have port usbclk, input, 1 bit: 12 MHz clock; the block uses one clock.
REQ-003 SHALL have port usbrst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port btn_nes, input, 8 bits: {right,left,down,up,start,select,b,a}, 1=pressed, synchronous to usbclk.
REQ-005 SHALL have port btn_x, input, 1 bit: turbo-A request, synchronous.
REQ-006 SHALL have port btn_y, input, 1 bit: turbo-B request, synchronous.
REQ-007 SHALL have port conerr, input, 1 bit: USB connection error, synchronous.
REQ-008 SHALL have port joy_strobe, input, 1 bit: console latch ($4016 bit0), asynchronous to usbclk.
REQ-009 SHALL have port joy_rd, input, 1 bit: console read clock, asynchronous to usbclk.
REQ-010 SHALL have port joy_data, output, 1 bit: serial button bit, 1=pressed.
REQ-011 SHALL have port btn_state, output, 8 bits: conditioned buttons, same order as btn_nes.
REQ-012 SHALL have port rd_count, output, 4 bits: shifts since last latch, saturating at 8.

Function
REQ-013 SHALL pass joy_strobe and joy_rd each through a 2-flop synchronizer plus one history flop; an edge is s2 != s3.
REQ-014 SHALL act on a synchronized edge or level at the 3rd usbclk rising edge after the raw input changes.
REQ-015 SHALL run turbo counter tcnt over 0..TURBO_HALF-1; on the wrap from TURBO_HALF-1 to 0 it toggles turbo_ph.
REQ-016 SHALL hold tcnt=0 and turbo_ph=1 while btn_x=0 and btn_y=0, so a turbo press registers at once.
REQ-017 SHALL compute eff = btn_nes, with eff[0] |= btn_x&turbo_ph and eff[1] |= btn_y&turbo_ph.
REQ-018 SHALL clear both eff[7:6] when left and right are both set; SHALL clear both eff[5:4] when up and down are both set.
REQ-019 SHALL force eff to 0, tcnt to 0 and turbo_ph to 1 while conerr=1.
REQ-020 SHALL register btn_state <= eff every cycle (1-cycle latency).
REQ-021 SHALL, while synchronized strobe is high, load sr[7:0] <= btn_state every cycle and set rd_count=0.
REQ-022 SHALL, on a synchronized joy_rd rising edge with strobe low, set sr <= {1'b1, sr[7:1]} and rd_count <= min(rd_count+1, 8).
REQ-023 SHALL ignore joy_rd edges while strobe is high; a load on the same cycle wins.
REQ-024 SHALL drive joy_data = sr[0] combinationally from the register, giving bit order A,B,Select,Start,Up,Down,Left,Right, then 1s.
REQ-025 SHALL freeze sr contents from the strobe falling edge until the next load; btn_nes changes do not affect a read in progress.
REQ-026 SHALL keep shifting 1s after the 8th shift, with rd_count held at 8.

Reset
REQ-027 SHALL, on usbrst_n=0, immediately clear sr, btn_state, rd_count, tcnt and all synchronizer flops, set turbo_ph=1, and drive joy_data=0.
REQ-028 SHALL, on reset mid-read, discard the read; after release, reads return 0 until the next strobe.

Verification
REQ-029 SHALL verify: btn_nes=8'h09, pulse strobe, 10 joy_rd pulses -> joy_data 1,0,0,1,0,0,0,0,1,1; rd_count ends at 8.
REQ-030 SHALL verify: TURBO_HALF=4, btn_x held, btn_nes=0 -> btn_state[0] pattern 1 for 4 cycles, 0 for 4 cycles, repeating from the first cycle after the press.
REQ-031 SHALL verify: btn_nes=8'hF0 -> btn_state=8'h00; btn_nes=8'h50 -> 8'h50.
REQ-032 SHALL verify: btn_nes=8'hFF, conerr=1, strobe then 8 reads -> joy_data 0 for all 8 bits.
REQ-033 SHALL verify: btn_nes changes 8'h01 -> 8'h02 after the strobe falls -> read returns A=1, B=0; joy_rd pulsed while strobe high -> rd_count stays 0.
REQ-034 SHALL verify: usbrst_n asserted after 3 shifts -> joy_data=0 and rd_count=0 in the same cycle, with no clock edge required.
